// File: rtl/load_store_unit_pkg.sv
// Shared decoder definitions for the data-memory path: access size encodings
// and the load/store unit FSM state type.
package load_store_unit_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_data_align.sv
// Combinational lane mapping for the load/store unit: byte enables, store-data
// replication, load extraction/extension and access legality.
module lsu_data_align (
    input  logic [2:0]  size,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    output logic [3:0]  be,
    output logic [31:0] wd_rep,
    output logic [31:0] rd_ext,
    output logic        legal
);
    import load_store_unit_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Unsigned sizes only exist for loads; a store carrying them is rejected.
    always_comb begin
        legal = 1'b0;
        case (size)
            LDST_B:  legal = 1'b1;
            LDST_BU: legal = ~we;
            LDST_H:  legal = ~addr_lo[0];
            LDST_HU: legal = ~we & ~addr_lo[0];
            LDST_W:  legal = (addr_lo == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        case (size[1:0])
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wd_rep[8*gi +: 8] = (size[1:0] == 2'd0) ? wd[7:0] :
                                       (size[1:0] == 2'd1) ? wd[8*(gi%2) +: 8] :
                                                             wd[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rd[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rd[31:16] : rd[15:0];

    always_comb begin
        rd_ext = 32'd0;
        case (size)
            LDST_B:  rd_ext = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: rd_ext = {24'd0, byte_sel};
            LDST_H:  rd_ext = {{16{half_sel[15]}}, half_sel};
            LDST_HU: rd_ext = {16'd0, half_sel};
            LDST_W:  rd_ext = rd;
            default: rd_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory responder for the core: issues one word-wide memory transaction
// per core access, stalls the core until ready, and flags bad accesses/timeouts.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        err_o
);
    import load_store_unit_pkg::*;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        drive_mem;

    logic [3:0]  al_be;
    logic [31:0] al_wd;
    logic [31:0] al_rd;
    logic        al_legal;

    lsu_data_align u_align (
        .size    (core_size_i),
        .we      (core_we_i),
        .addr_lo (core_addr_i[1:0]),
        .wd      (core_wd_i),
        .rd      (mem_rd_i),
        .be      (al_be),
        .wd_rep  (al_wd),
        .rd_ext  (al_rd),
        .legal   (al_legal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        drive_mem    = 1'b0;
        core_stall_o = 1'b0;
        core_rd_o    = 32'd0;
        err_o        = 1'b0;

        // Outputs are forced quiet while reset is held, even with a request present.
        if (!rst_i) begin
            case (state_reg)
                ST_IDLE: begin
                    if (core_req_i) begin
                        if (al_legal) begin
                            drive_mem    = 1'b1;
                            core_stall_o = 1'b1;
                            state_next   = ST_WAIT;
                            cnt_next     = 8'd0;
                        end else begin
                            err_o = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!core_req_i) begin
                        // Core abandoned the access: silently abort.
                        state_next = ST_IDLE;
                        cnt_next   = 8'd0;
                    end else begin
                        drive_mem = 1'b1;
                        if (mem_ready_i) begin
                            core_rd_o  = core_we_i ? 32'd0 : al_rd;
                            state_next = ST_IDLE;
                        end else if (cnt_reg == TIMEOUT_LAST) begin
                            err_o      = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            core_stall_o = 1'b1;
                            cnt_next     = cnt_reg + 8'd1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign mem_req_o  = drive_mem;
    assign mem_we_o   = drive_mem & core_we_i;
    assign mem_be_o   = drive_mem ? al_be : 4'd0;
    assign mem_addr_o = drive_mem ? core_addr_i : 32'd0;
    assign mem_wd_o   = drive_mem ? al_wd : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus randomized
// accesses checked against a byte-arithmetic reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wd = 32'd0;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = 32'd0;
    logic        mem_ready = 1'b0;
    logic        err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int          stall_cycles;
        int          err_cnt;
        int          cycles;
        bit          done;
        bit          req_first;
        bit          we_first;
        logic [3:0]  be_first;
        logic [31:0] wd_first;
        logic [31:0] addr_first;
        logic [31:0] rd_done;
    } obs_t;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready),
        .err_o        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [2:0] size);
        case (size)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_legal(input bit we, input logic [2:0] size, input logic [31:0] addr);
        int n = m_bytes(size);
        if (n == 0) return 0;
        if (we && size > 3'd3) return 0;
        return (addr % n) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
        int n = m_bytes(size);
        int v = ((1 << n) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
        int n = m_bytes(size);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = 8'((wd >> (8 * (i % n))) & 32'hFF);
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] rd);
        int n = m_bytes(size);
        longint v;
        longint span;
        span = longint'(1) << (8 * n);
        v = (longint'(rd) >> (8 * (addr % 4))) % span;
        if (size < 3'd3 && n < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // Drives one access and records what the DUT did; checks live in the callers.
    // lat: cycle index (>=1) at which mem_ready rises; 0 means never.
    task automatic run_access(input bit we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] memrd, input int lat,
                              output obs_t o);
        o = '{stall_cycles: 0, err_cnt: 0, cycles: 0, done: 0, req_first: 0, we_first: 0,
              be_first: 4'd0, wd_first: 32'd0, addr_first: 32'd0, rd_done: 32'd0};
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        mem_rd = memrd;
        for (int c = 0; c < 200; c++) begin
            mem_ready = (lat > 0) && (c >= lat);
            #4;
            if (c == 0) begin
                o.req_first = mem_req; o.we_first = mem_we; o.be_first = mem_be;
                o.wd_first = mem_wd; o.addr_first = mem_addr;
            end
            if (err) o.err_cnt++;
            if (core_stall) o.stall_cycles++;
            else begin o.rd_done = core_rd; o.done = 1; o.cycles = c + 1; end
            @(posedge clk); #1;
            if (o.done) break;
        end
        core_req = 1'b0; mem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [103:0] allo;
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h0;
        #3;
        allo = {mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, core_stall, err};
        total++;
        if (allo !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", allo); end
        @(posedge clk); #1; rst = 1'b0; core_req = 1'b0;
        #4;
        allo = {mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, core_stall, err};
        total++;
        if (allo !== '0) begin bad++; $display("FAIL idle_outputs: got %h want 0", allo); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        obs_t o;
        run_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1, o);
        $display("txn LB  addr=103 rd=%h stall=%0d", o.rd_done, o.stall_cycles);
        total++; if (o.be_first !== 4'h8) begin bad++; $display("FAIL lb_be: got %h want 8", o.be_first); end
        total++; if (o.rd_done !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rd: got %h want ffffff80", o.rd_done); end
        total++; if (o.stall_cycles != 1) begin bad++; $display("FAIL lb_stall: got %0d want 1", o.stall_cycles); end

        run_access(1'b0, 3'd5, 32'h22, 32'h0, 32'hBEEF_0000, 3, o);
        $display("txn LHU addr=22 rd=%h stall=%0d", o.rd_done, o.stall_cycles);
        total++; if (o.rd_done !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_rd: got %h want 0000beef", o.rd_done); end
        total++; if (o.stall_cycles != 3) begin bad++; $display("FAIL lhu_stall: got %0d want 3", o.stall_cycles); end

        run_access(1'b1, 3'd0, 32'h41, 32'h1234_56AB, 32'h0, 1, o);
        $display("txn SB  addr=41 be=%h wd=%h", o.be_first, o.wd_first);
        total++; if (o.we_first !== 1'b1) begin bad++; $display("FAIL sb_we: got %b want 1", o.we_first); end
        total++; if (o.be_first !== 4'h2) begin bad++; $display("FAIL sb_be: got %h want 2", o.be_first); end
        total++; if (o.wd_first !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wd: got %h want abababab", o.wd_first); end

        run_access(1'b1, 3'd1, 32'h42, 32'h1234_56AB, 32'h0, 1, o);
        $display("txn SH  addr=42 be=%h wd=%h", o.be_first, o.wd_first);
        total++; if (o.be_first !== 4'hC) begin bad++; $display("FAIL sh_be: got %h want c", o.be_first); end
        total++; if (o.wd_first !== 32'h56AB_56AB) begin bad++; $display("FAIL sh_wd: got %h want 56ab56ab", o.wd_first); end

        run_access(1'b0, 3'd2, 32'h06, 32'h0, 32'h0, 1, o);
        $display("txn LW  addr=06 err=%0d req=%b", o.err_cnt, o.req_first);
        total++; if (o.err_cnt != 1) begin bad++; $display("FAIL lw_mis_err: got %0d want 1", o.err_cnt); end
        total++; if (o.req_first !== 1'b0) begin bad++; $display("FAIL lw_mis_req: got %b want 0", o.req_first); end
        total++; if (o.stall_cycles != 0) begin bad++; $display("FAIL lw_mis_stall: got %0d want 0", o.stall_cycles); end

        run_access(1'b1, 3'd4, 32'h10, 32'h55, 32'h0, 1, o);
        $display("txn SB(size4) addr=10 err=%0d", o.err_cnt);
        total++; if (o.err_cnt != 1) begin bad++; $display("FAIL sbu_err: got %0d want 1", o.err_cnt); end
        total++; if (o.req_first !== 1'b0) begin bad++; $display("FAIL sbu_req: got %b want 0", o.req_first); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, o);
        $display("txn LW timeout stall=%0d err=%0d rd=%h", o.stall_cycles, o.err_cnt, o.rd_done);
        total++; if (o.stall_cycles != TO) begin bad++; $display("FAIL to_stall: got %0d want %0d", o.stall_cycles, TO); end
        total++; if (o.err_cnt != 1) begin bad++; $display("FAIL to_err: got %0d want 1", o.err_cnt); end
        total++; if (o.rd_done !== 32'd0) begin bad++; $display("FAIL to_rd: got %h want 0", o.rd_done); end
        #4;
        total++; if ({err, mem_req, core_stall} !== 3'b000) begin bad++; $display("FAIL to_after: got %b want 000", {err, mem_req, core_stall}); end
        @(posedge clk); #1;
        run_access(1'b0, 3'd2, 32'h104, 32'h0, 32'h0BAD_F00D, 1, o);
        $display("txn LW after timeout stall=%0d rd=%h", o.stall_cycles, o.rd_done);
        total++; if (o.stall_cycles != 1) begin bad++; $display("FAIL to_idle_stall: got %0d want 1", o.stall_cycles); end
        total++; if (o.rd_done !== 32'h0BAD_F00D) begin bad++; $display("FAIL to_idle_rd: got %h want 0badf00d", o.rd_done); end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        int c0;
        c0 = cyc;
        run_access(1'b1, 3'd2, 32'h200, 32'hCAFE_F00D, 32'h0, 1, o1);
        run_access(1'b0, 3'd2, 32'h204, 32'h0, 32'h1357_9BDF, 1, o2);
        $display("txn SW+LW b2b cycles=%0d rd=%h", cyc - c0, o2.rd_done);
        total++; if (o1.wd_first !== 32'hCAFE_F00D || o1.be_first !== 4'hF) begin bad++; $display("FAIL b2b_sw: got be=%h wd=%h want f cafef00d", o1.be_first, o1.wd_first); end
        total++; if (o2.req_first !== 1'b1) begin bad++; $display("FAIL b2b_req: got %b want 1", o2.req_first); end
        total++; if (cyc - c0 != 4) begin bad++; $display("FAIL b2b_cycles: got %0d want 4", cyc - c0); end
        total++; if (o2.rd_done !== 32'h1357_9BDF) begin bad++; $display("FAIL b2b_rd: got %h want 13579bdf", o2.rd_done); end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        logic [103:0] allo;
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h300; mem_ready = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        allo = {mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, core_stall, err};
        $display("txn reset mid-wait outputs=%h", allo);
        total++; if (allo !== '0) begin bad++; $display("FAIL rst_wait_outputs: got %h want 0", allo); end
        @(posedge clk); #1; rst = 1'b0; core_req = 1'b0;
        run_access(1'b0, 3'd1, 32'h302, 32'h0, 32'h8001_0000, 2, o);
        $display("txn LH after reset stall=%0d rd=%h", o.stall_cycles, o.rd_done);
        total++; if (o.stall_cycles != 2) begin bad++; $display("FAIL rst_wait_stall: got %0d want 2", o.stall_cycles); end
        total++; if (o.rd_done !== 32'hFFFF_8001) begin bad++; $display("FAIL rst_wait_rd: got %h want ffff8001", o.rd_done); end
    endtask

    task automatic test_drop_req();
        obs_t o;
        logic [103:0] allo;
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h400; mem_ready = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b0;
        #4;
        allo = {mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, core_stall, err};
        $display("txn drop req in wait outputs=%h", allo);
        total++; if (allo !== '0) begin bad++; $display("FAIL drop_outputs: got %h want 0", allo); end
        @(posedge clk); #1;
        run_access(1'b0, 3'd4, 32'h401, 32'h0, 32'h0000_9A00, 1, o);
        total++; if (o.stall_cycles != 1 || o.rd_done !== 32'h0000_009A || o.err_cnt != 0) begin
            bad++; $display("FAIL drop_next: got stall=%0d rd=%h err=%0d want 1 0000009a 0", o.stall_cycles, o.rd_done, o.err_cnt);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 60; i++) begin
            bit          we = 1'($urandom_range(0, 1));
            logic [2:0]  size = 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rdw = $urandom;
            int          lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            bit          lg = m_legal(we, size, addr);
            int          exp_stall = !lg ? 0 : (lat == 0 ? TO : lat);
            int          exp_err = (!lg || lat == 0) ? 1 : 0;
            logic [31:0] exp_rd = (!lg || lat == 0 || we) ? 32'd0 : m_rd(size, addr, rdw);
            run_access(we, size, addr, wd, rdw, lat, o);
            $display("txn rnd%0d we=%0d size=%0d addr=%h lat=%0d legal=%0d rd=%h", i, we, size, addr, lat, lg, o.rd_done);
            total++; if (o.done !== 1'b1) begin bad++; $display("FAIL rnd_done[%0d]: got %b want 1", i, o.done); end
            total++; if (o.stall_cycles != exp_stall) begin bad++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, o.stall_cycles, exp_stall); end
            total++; if (o.err_cnt != exp_err) begin bad++; $display("FAIL rnd_err[%0d]: got %0d want %0d", i, o.err_cnt, exp_err); end
            total++; if (o.rd_done !== exp_rd) begin bad++; $display("FAIL rnd_rd[%0d]: got %h want %h", i, o.rd_done, exp_rd); end
            total++; if (o.req_first !== lg) begin bad++; $display("FAIL rnd_req[%0d]: got %b want %b", i, o.req_first, lg); end
            if (lg) begin
                total++; if (o.be_first !== m_be(size, addr)) begin bad++; $display("FAIL rnd_be[%0d]: got %h want %h", i, o.be_first, m_be(size, addr)); end
                total++; if (o.addr_first !== addr || o.we_first !== we) begin bad++; $display("FAIL rnd_addr_we[%0d]: got %h/%b want %h/%b", i, o.addr_first, o.we_first, addr, we); end
                if (we) begin
                    total++; if (o.wd_first !== m_wd(size, wd)) begin bad++; $display("FAIL rnd_wd[%0d]: got %h want %h", i, o.wd_first, m_wd(size, wd)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_drop_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Responder for the processor core's data-memory request interface: accepts the core's request and returns the read data and the stall.
- Translates core accesses (byte/half/word, signed/unsigned) into word-wide data-memory transactions with byte enables, lane replication and load extension.
- Holds the core stalled until memory signals ready.
- Detects misaligned/illegal-size accesses and memory timeouts; reports them on err_o.

Parameters:
- TIMEOUT_CYCLES, 16: max WAIT cycles without mem_ready_i before abort; legal range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- core_req_i  in  1  core access request; held stable by core while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, LSB-aligned
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  stall to core
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  memory address, = core_addr_i
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory completion, valid only while mem_req_o=1
- err_o  out  1  one-cycle pulse: misaligned, illegal size, or timeout

Behaviour:
- Reset is rst_i, asynchronous, active-high; clock is clk_i. Reset forces state=IDLE and cnt=0. With core_req_i=0, every output is 0.
- Aligned legality:
  - B/BU: always legal.
  - H/HU: addr[0]=0.
  - W: addr[1:0]=0.
  - Sizes 3, 6, 7: illegal.
  - Stores use core_size_i[1:0] only; size 4/5 on a store is illegal.
- FSM states: IDLE, WAIT.
- IDLE:
  - core_req_i=1 and legal: mem_req_o=1 and core_stall_o=1 combinationally; next state WAIT, cnt cleared.
  - core_req_i=1 and illegal: mem_req_o=0, core_stall_o=0, core_rd_o=0, err_o=1 in the same cycle; state stays IDLE.
  - core_req_i=0: all outputs 0.
- WAIT:
  - mem_req_o=1; mem_we_o, mem_be_o, mem_wd_o and mem_addr_o are driven from the held core inputs.
  - core_stall_o = ~mem_ready_i.
  - On mem_ready_i=1: core_rd_o = extended mem_rd_i in the same cycle (loads; 0 for stores); next state IDLE.
  - Otherwise cnt increments. When cnt reaches TIMEOUT_CYCLES-1 with no ready: core_stall_o=0, core_rd_o=0, err_o=1, next state IDLE.
- Latency: minimum one stalled cycle; response is available in the second cycle of the request.
- Back-to-back requests: a request in the cycle after completion is taken as new from IDLE. There are no bubbles beyond the minimum latency.
- core_req_i dropping in WAIT is a protocol violation. Required response: abort to IDLE, no err_o.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
  - mem_be_o is driven for loads too.
- Write data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd unchanged.
- Load extension: the byte is selected by addr[1:0], the half by addr[1].
  - B/H: sign-extended.
  - BU/HU: zero-extended.
  - W: passthrough.
- Reset mid-WAIT: immediate return to IDLE; all outputs 0 while reset is asserted.

Decomposition:
- Size encodings (LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5) are already in the shared decoder package; reuse them, do not duplicate.
- The FSM state enum goes in the same package.
- One combinational sub-module, lsu_data_align, implements the three mappings:
  - (size, addr[1:0], wd) -> (be, wd_rep).
  - (size, addr[1:0], rd) -> rd_ext.
  - (size, we, addr) -> legal.
- FSM and timeout counter stay in load_store_unit.

Test Plan:
- LB, addr=0x103, mem returns 0x80FF_1234 with ready on the 2nd cycle -> mem_be_o=0x8, core_rd_o=0xFFFF_FF80, stall high for exactly 1 cycle.
- LHU, addr=0x22, mem_rd_i=0xBEEF_0000 with 3 cycles of ready latency -> core_rd_o=0x0000_BEEF, stall high for 3 cycles, then drops with ready.
- SB, addr=0x41, wd=0x1234_56AB -> mem_we_o=1, mem_be_o=0x2, mem_wd_o=0xABAB_ABAB; SH at 0x42 -> be=0xC, wd replicates the half.
- LW, addr=0x06 -> err_o=1 same cycle, mem_req_o=0, core_stall_o=0; SB with size=4 -> err_o=1.
- TIMEOUT_CYCLES=4, mem_ready_i stuck 0 -> stall for 4 cycles then drops, err_o pulses once, core_rd_o=0, FSM in IDLE.
- Back-to-back SW then LW, plus rst_i asserted mid-WAIT -> second access starts the cycle after the first completes; reset clears all outputs and returns the FSM to IDLE.
